// File: rtl/uv_uart_autobaud.sv
// Automatic baud-rate detector: times a 0x55 character on the RX line and
// produces the bit period in clk cycles for the UART engines.
module uv_uart_autobaud #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TMO     = 65535,
  parameter int unsigned MIN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_cause,
  output logic [CNT_W-1:0] clk_div,
  output logic             div_vld
);

  localparam int unsigned TOT_W = CNT_W + 3;
  localparam int unsigned DIV_W = CNT_W + 4;
  localparam int unsigned SEG_W = $clog2(TMO + 1);
  localparam int unsigned CMP_W = ((CNT_W > SEG_W) ? CNT_W : SEG_W) + 1;

  localparam logic [TOT_W:0]   TOT_ONE = (TOT_W + 1)'(1);
  localparam logic [SEG_W-1:0] SEG_ONE = SEG_W'(1);
  localparam logic [SEG_W-1:0] TMO_V   = SEG_W'(TMO);
  localparam logic [DIV_W-1:0] DIV_LIM = {4'b0001, {CNT_W{1'b0}}};
  localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_TMO   = 2'd1;
  localparam logic [1:0] CAUSE_RANGE = 2'd2;
  localparam logic [1:0] CAUSE_FRAME = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_MEAS,
    ST_STOP
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync2_q, dly_q;
  logic [TOT_W-1:0] total_q, total_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] clk_div_q, clk_div_d;
  logic             vld_q, vld_d;

  logic             edge_any, fall, rise;
  logic [TOT_W:0]   total_inc;
  logic             tot_ovf;
  logic [SEG_W-1:0] seg_inc;
  logic             seg_tmo;
  logic [DIV_W-1:0] div_calc;
  logic             div_bad;
  logic [CMP_W-1:0] seg_x, half_x, hi_x;
  logic             frame_bad;

  // Both edge polarities pass through the same three flops, so edge spacing
  // seen here equals spacing on the pin.
  assign edge_any = sync2_q ^ dly_q;
  assign fall     = dly_q & ~sync2_q;
  assign rise     = sync2_q & ~dly_q;

  assign total_inc = {1'b0, total_q} + TOT_ONE;
  assign tot_ovf   = total_inc[TOT_W];
  assign seg_inc   = seg_q + SEG_ONE;
  assign seg_tmo   = (seg_inc == TMO_V);

  // total_inc is t(F5)-t(F1) on the F5 cycle; divide by 8 with round-half-up.
  assign div_calc = (DIV_W'(total_inc[TOT_W-1:0]) + DIV_W'(4)) >> 3;
  assign div_bad  = (div_calc >= DIV_LIM) || (div_calc < MIN_V);

  assign seg_x     = CMP_W'(seg_inc);
  assign half_x    = CMP_W'(div_q >> 1);
  assign hi_x      = CMP_W'(div_q) + half_x;
  assign frame_bad = (seg_x < half_x) || (seg_x > hi_x);

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    seg_d     = seg_q;
    fcnt_d    = fcnt_q;
    div_d     = div_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cause_d   = cause_q;
    clk_div_d = clk_div_q;
    vld_d     = vld_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vld_d   = 1'b0;
            cause_d = CAUSE_NONE;
            state_d = ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (fall) begin
            total_d = '0;
            seg_d   = '0;
            fcnt_d  = 3'd1;
            state_d = ST_MEAS;
          end
        end
        ST_MEAS: begin
          total_d = total_inc[TOT_W-1:0];
          seg_d   = edge_any ? '0 : seg_inc;
          if (fall) begin
            fcnt_d = fcnt_q + 3'd1;
          end
          if (seg_tmo) begin
            err_d   = 1'b1;
            cause_d = CAUSE_TMO;
            state_d = ST_IDLE;
          end else if (tot_ovf) begin
            err_d   = 1'b1;
            cause_d = CAUSE_RANGE;
            state_d = ST_IDLE;
          end else if (fall && (fcnt_q == 3'd4)) begin
            if (div_bad) begin
              err_d   = 1'b1;
              cause_d = CAUSE_RANGE;
              state_d = ST_IDLE;
            end else begin
              div_d   = div_calc[CNT_W-1:0];
              state_d = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          seg_d = seg_inc;
          if (seg_tmo) begin
            err_d   = 1'b1;
            cause_d = CAUSE_TMO;
            state_d = ST_IDLE;
          end else if (rise) begin
            if (frame_bad) begin
              err_d   = 1'b1;
              cause_d = CAUSE_FRAME;
            end else begin
              done_d    = 1'b1;
              clk_div_d = div_q;
              vld_d     = 1'b1;
            end
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      dly_q     <= 1'b1;
      state_q   <= ST_IDLE;
      total_q   <= '0;
      seg_q     <= '0;
      fcnt_q    <= '0;
      div_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
      clk_div_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      dly_q     <= sync2_q;
      state_q   <= state_d;
      total_q   <= total_d;
      seg_q     <= seg_d;
      fcnt_q    <= fcnt_d;
      div_q     <= div_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cause_q   <= cause_d;
      clk_div_q <= clk_div_d;
      vld_q     <= vld_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_cause = cause_q;
  assign clk_div   = clk_div_q;
  assign div_vld   = vld_q;

endmodule

// File: doc/uv_uart_autobaud.md
# uv_uart_autobaud

Automatic baud-rate detector for the UART receive line. On request it watches `uart_rx` for a host-sent 0x55 ('U') character in 8N1 framing and measures the bit period in `clk` cycles. It produces a `clk_div` value that the register block loads into the UART TX/RX engines. It sits beside the RX engine on the serial input, upstream of the UART control registers.

## Interface
- `CNT_W`, 16: width of `clk_div` result.
- `TMO`, 65535: max clk cycles allowed between consecutive detected edges while measuring.
- `MIN_DIV`, 4: smallest legal result; smaller values are an error.
- `clk`  in  1  the single clock for the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `uart_rx`  in  1  raw serial line (asynchronous, idle high).
- `start`  in  1  one-cycle request to begin detection; honoured only in IDLE.
- `abort`  in  1  return to IDLE without `done` or `err`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a valid result is produced.
- `err`  out  1  one-cycle pulse when detection fails.
- `err_cause`  out  2  held: 0 none, 1 timeout, 2 overflow/range, 3 framing.
- `clk_div`  out  CNT_W  last valid bit period in clk cycles.
- `div_vld`  out  1  `clk_div` holds a result from the most recent detection.

## Operation
- Input path: 2-flop synchronizer (reset to 1), then one delay flop. Edge detect compares the synchronized value with the delayed value. Both edge types have equal latency, so measurements are unaffected.
- 0x55 line pattern, LSB first: start 0, then 1,0,1,0,1,0,1,0, then stop 1. Falling edges F1..F5 occur at the start of the start bit, b1, b3, b5 and b7. F1 to F5 spans exactly 8 bit periods.
- States:
  - IDLE: on `start`, clear `div_vld`, clear `err_cause`, go to HUNT.
  - HUNT: wait for F1 with no timeout. At F1, zero `total` and `seg`, set falling-edge count = 1, go to MEAS.
  - MEAS: each cycle, `total` and `seg` increment. Every detected edge (either polarity) clears `seg`; every falling edge increments the count. At F5, capture `total` and go to STOP.
  - STOP: wait for the rising edge that starts the stop bit. `seg` is measured from F5. Then go to IDLE with `done` or `err`.
- Arithmetic:
  - `total` is CNT_W+3 bits and equals t(F5) − t(F1) exactly.
  - If `total` would exceed its maximum: `err`, cause 2.
  - `div = (total + 4) >> 3`, computed in CNT_W+4 bits (round to nearest, ties up).
  - If `div` ≥ 2^CNT_W or `div` < MIN_DIV: `err`, cause 2.
- Framing: in STOP, the rising edge must arrive with `div/2` ≤ `seg` ≤ `div + div/2` (integer shifts). Otherwise `err`, cause 3.
- Timeout: in MEAS or STOP, if `seg` reaches TMO: `err`, cause 1.
- Success: `clk_div` ← `div`, `div_vld` ← 1, `done` pulses. On any error, `clk_div` and `div_vld` stay unchanged from the start of the run (`div_vld` remains 0).
- `abort` has priority over every other event in every state: next state is IDLE, no pulse, `err_cause` unchanged.
- `start` while busy is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `err_cause`=0, `clk_div`=0, `div_vld`=0, state IDLE, synchronizer flops = 1.
- Pin-to-edge-detect latency: 3 cycles.
- `start` sampled at edge N gives `busy`=1 from cycle N+1.
- `done`/`err` pulse in the cycle after the terminating edge or timeout is detected. `clk_div`, `div_vld` and `err_cause` update in that same cycle. `busy` drops in that same cycle.
- Range checks on `div` are evaluated at F5, so a range error pulses `err` the cycle after F5.
- Simultaneous `done`/`err` conditions cannot occur; error checks take priority over success.
- Reset asserted mid-run: immediate return to reset values, no pulse.

## Test plan
- 0x55 at 16 clk/bit, `start` beforehand → `total`=128, `clk_div`=16, `div_vld`=1, one `done`, `err`=0.
- 0x55 at 17 clk/bit → `total`=136, `clk_div`=17. Edge spacing giving `total`=131 → 16; `total`=132 → 17 (rounding).
- `TMO`=200, line held low 300 cycles after F1 → `err` with `err_cause`=1, `div_vld`=0, `clk_div` keeps its previous value.
- 0x55 at 2 clk/bit, `MIN_DIV`=4 → `err` with `err_cause`=2 the cycle after F5.
- 0x55 at 16 clk/bit but stop-bit rising edge 40 cycles after F5 → `err` with `err_cause`=3.
- `abort` asserted in MEAS, and separately `rst` asserted in STOP → IDLE next cycle, no `done`/`err`. A second `start` pulse while busy has no effect.
